// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// multi-cycle EX occupancy states.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned MC_CNT_W = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage operand forwarding select for one source register; MEM result
// takes priority over WB result, x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs_e,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  output fwd_sel_t         o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_reg_write_m && (i_rd_m != REG_W'(0)) && (i_rd_m == i_rs_e);
  assign w_hit_w = i_reg_write_w && (i_rd_w != REG_W'(0)) && (i_rd_w == i_rs_e);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m) begin
      o_sel = FWD_MEM;
    end else if (w_hit_w) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stalls, branch
// flushes, multi-cycle EX occupancy and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  fwd_sel_t              w_fwd_a;
  fwd_sel_t              w_fwd_b;
  mc_state_t             r_state;
  mc_state_t             w_state_nxt;
  logic [MC_CNT_W-1:0]   r_cnt;
  logic [MC_CNT_W-1:0]   w_cnt_nxt;
  logic                  w_mc_stall;
  logic                  w_lw_stall;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  fwd_sel u_fwd_a (
    .i_rs_e        (Rs1E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_rs_e        (Rs2E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_b)
  );

  assign forwardA = reset ? FWD_RF : w_fwd_a;
  assign forwardB = reset ? FWD_RF : w_fwd_b;

  assign w_lw_stall = (r_state == IDLE) && ResultSrcE0 && (RdE != REG_W'(0)) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state plus stall/flush enables; multi-cycle hold dominates, flush beats load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;

    case (r_state)
      IDLE: begin
        if (MultiCycleE) begin
          w_mc_stall  = 1'b1;
          w_cnt_nxt   = MC_CNT_W'(MC_LATENCY - 2);
          w_state_nxt = (MC_LATENCY >= 3) ? BUSY : DONE;
        end
      end
      BUSY: begin
        w_mc_stall = 1'b1;
        if (r_cnt == MC_CNT_W'(1)) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - MC_CNT_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (!reset) begin
      if (w_mc_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        StallF = w_lw_stall && !PCSrcE;
        StallD = w_lw_stall && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = w_lw_stall || PCSrcE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (FlushE && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl: two instances (latency 4 /
// 32-bit counters and latency 2 / 2-bit counters) against an occupancy model.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, fd0, fe0, fm0;
  logic        sf1, sd1, se1, fd1, fe1, fm1;
  logic [31:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  int n_chk;
  int n_fail;

  longint occ  [2];
  longint scnt [2];
  longint fcnt [2];
  longint lat  [2];
  longint cmax [2];

  hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
    .forwardA(fa0), .forwardB(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0),
    .FlushD(fd0), .FlushE(fe0), .FlushM(fm0), .StallCount(sc0), .FlushCount(fc0)
  );

  hazard_ctrl #(.MC_LATENCY(2), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
    .forwardA(fa1), .forwardB(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .StallCount(sc1), .FlushCount(fc1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  // Model: occ = EX cycles still owed by a multi-cycle op (last one is the release cycle).
  task automatic model_check(input int k, input string p,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic sf, input logic sd, input logic se,
                             input logic fd, input logic fe, input logic fm,
                             input longint sc, input longint fc);
    bit idle, mc, lw;
    bit e_sf, e_se, e_fd, e_fe;
    if (reset) begin
      occ[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      check({p, "rst_fa"}, fa, 0);
      check({p, "rst_fb"}, fb, 0);
      check({p, "rst_stall"}, {sf, sd, se}, 0);
      check({p, "rst_flush"}, {fd, fe, fm}, 0);
      check({p, "rst_scnt"}, sc, 0);
      check({p, "rst_fcnt"}, fc, 0);
      return;
    end
    idle = (occ[k] == 0);
    if (idle && MultiCycleE) occ[k] = lat[k];
    mc = (occ[k] > 1);
    lw = idle && !mc && ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    e_sf = mc || (lw && !PCSrcE);
    e_se = mc;
    e_fd = !mc && PCSrcE;
    e_fe = !mc && (lw || PCSrcE);
    check({p, "forwardA"}, fa, ref_fwd(Rs1E));
    check({p, "forwardB"}, fb, ref_fwd(Rs2E));
    check({p, "StallF"}, sf, e_sf);
    check({p, "StallD"}, sd, e_sf);
    check({p, "StallE"}, se, e_se);
    check({p, "FlushD"}, fd, e_fd);
    check({p, "FlushE"}, fe, e_fe);
    check({p, "FlushM"}, fm, e_se);
    check({p, "StallCount"}, sc, scnt[k]);
    check({p, "FlushCount"}, fc, fcnt[k]);
    if (e_sf && scnt[k] < cmax[k]) scnt[k]++;
    if (e_fe && fcnt[k] < cmax[k]) fcnt[k]++;
    if (occ[k] > 0) occ[k]--;
  endtask

  // One clock: apply reset level, check both instances, advance to next negedge.
  task automatic step(input logic rst_i);
    reset = rst_i;
    #1;
    model_check(0, "L4.", fa0, fb0, sf0, sd0, se0, fd0, fe0, fm0, longint'(sc0), longint'(fc0));
    model_check(1, "L2.", fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, longint'(sc1), longint'(fc1));
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE} = '0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    lat[0] = 4; lat[1] = 2;
    cmax[0] = 64'h0000_0000_FFFF_FFFF; cmax[1] = 3;
    occ = '{0, 0}; scnt = '{0, 0}; fcnt = '{0, 0};
    clk = 1'b0;
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    step(1'b1);
    step(1'b1);

    Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
    step(1'b0);
    check("fwd_mem_prio", fa0, 2);
    RegWriteM = 0;
    step(1'b0);
    check("fwd_wb", fa0, 1);
    RdM = 0; RdW = 0; RegWriteM = 1;
    step(1'b0);
    check("fwd_x0", fa0, 0);
    clear_inputs();

    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    step(1'b0);
    check("lw_stallcount", sc0, 1);
    RdE = 0;
    step(1'b0);
    clear_inputs();

    PCSrcE = 1;
    step(1'b0);
    check("br_flushcount", fc0, 2);
    ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    step(1'b0);
    clear_inputs();
    step(1'b0);

    MultiCycleE = 1;
    repeat (5) step(1'b0);
    check("mc_stallcount", sc0, 5);
    clear_inputs();
    step(1'b0);

    MultiCycleE = 1;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("mid_rst_stallE", se0, 0);
    clear_inputs();
    step(1'b0);
    check("post_rst_cnt", sc0, 0);

    ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
    repeat (5) step(1'b0);
    check("sat_stallcount", sc1, 3);
    clear_inputs();

    for (int i = 0; i < 3000; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE      = ($urandom_range(0, 5) == 0);
      MultiCycleE = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
